// File: rtl/dth_ctrl.sv
// dth_ctrl: single-wire humidity/temperature sensor controller.
// Drives the start pulse, then decodes the 40-bit response by timing the high
// phase of each bit. A valid checksum loads DTH_data; a bad one or a stuck
// line sets a sticky error.
module dth_ctrl #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TIMEOUT_US = 100
) (
    input  logic        clk,
    input  logic        rst_n,          // active-high asynchronous reset
    input  logic        start,
    inout  wire logic   DTH,
    output logic        error,
    output logic [39:0] DTH_data,
    output logic        DHT_data_ready
);

    // Phase lengths in clock cycles
    localparam int unsigned START_LOW_CYC  = CLK_HZ / 50;          // 20 ms
    localparam int unsigned START_HIGH_CYC = CLK_HZ / 50_000;      // 20 us
    localparam int unsigned BIT_ONE_CYC    = CLK_HZ / 25_000;      // 40 us
    localparam int unsigned TIMEOUT_CYC    = (CLK_HZ / 1_000) * TIMEOUT_US / 1_000;

    localparam int unsigned MAX_A   = (START_LOW_CYC > TIMEOUT_CYC) ? START_LOW_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_MAX = (MAX_A > BIT_ONE_CYC) ? MAX_A : BIT_ONE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LOW_LAST  = CNT_W'(START_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] START_HIGH_LAST = CNT_W'(START_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_ONE_LIM     = CNT_W'(BIT_ONE_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM     = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        START_HIGH,
        RESP_WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW,
        DONE,
        FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [39:0]      shift_q, shift_d;
    logic [39:0]      data_q, data_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [1:0]       sync_q;
    logic             prev_q;

    logic             dth_s;
    logic             rise;
    logic             fall;
    logic             timed_out;
    logic             bit_val;
    logic [7:0]       csum;

    assign dth_s     = sync_q[1];
    assign rise      = dth_s & ~prev_q;
    assign fall      = ~dth_s & prev_q;
    assign timed_out = (cnt_q >= TIMEOUT_LIM);
    assign bit_val   = (cnt_q > BIT_ONE_LIM);
    assign csum      = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

    // Line is only ever driven during the host start pulse; otherwise released
    assign DTH = (state_q == START_LOW)  ? 1'b0 :
                 (state_q == START_HIGH) ? 1'b1 : 1'bz;

    assign error          = err_q;
    assign DTH_data       = data_q;
    assign DHT_data_ready = ready_q;

    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], DTH};
            prev_q <= dth_s;
        end
    end

    // State, counters and result registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    // Next-state: phase sequencing, bit decoding, timeouts and checksum
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = ready_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    err_d     = 1'b0;
                    ready_d   = 1'b0;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = START_LOW;
                end
            end
            START_LOW: begin
                if (cnt_q == START_LOW_LAST) begin
                    cnt_d   = '0;
                    state_d = START_HIGH;
                end
            end
            START_HIGH: begin
                if (cnt_q == START_HIGH_LAST) begin
                    cnt_d   = '0;
                    state_d = RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                if (!dth_s) begin
                    cnt_d   = '0;
                    state_d = RESP_LOW;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            RESP_LOW: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = RESP_HIGH;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            RESP_HIGH: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = BIT_LOW;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            BIT_LOW: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = BIT_HIGH;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            BIT_HIGH: begin
                if (fall) begin
                    cnt_d     = '0;
                    shift_d   = {shift_q[38:0], bit_val};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd39) ? END_LOW : BIT_LOW;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            END_LOW: begin
                if (rise) begin
                    cnt_d = '0;
                    if (csum == shift_q[7:0]) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FAIL;
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            DONE, FAIL: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dth_ctrl.sv
// tb_dth_ctrl: open-drain sensor model with a pull-up, scoreboard of expected
// measurement results, one task per scenario.
module tb_dth_ctrl;

    localparam int unsigned CLK_HZ     = 250_000;
    localparam int unsigned TIMEOUT_US = 100;

    // Expected timings derived from wall-clock values at CLK_HZ
    localparam int START_LOW  = CLK_HZ / 50;                       // 20 ms
    localparam int START_HIGH = CLK_HZ / 50_000;                   // 20 us
    localparam int TO         = (CLK_HZ / 1000) * TIMEOUT_US / 1000;
    localparam int RESP       = (CLK_HZ / 1000) * 800 / 10_000;    // 80 us
    localparam int BLOW       = (CLK_HZ / 1000) * 500 / 10_000;    // 50 us
    localparam int H0         = (CLK_HZ / 1000) * 265 / 10_000;    // 26.5 us
    localparam int H1         = (CLK_HZ / 1000) * 700 / 10_000;    // 70 us

    typedef struct packed {
        logic [39:0] data;
        logic        rdy;
        logic        err;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        sens_low = 1'b0;
    wire         DTH;
    logic        error;
    logic [39:0] DTH_data;
    logic        rdy;

    int          total = 0;
    int          bad   = 0;
    logic [39:0] last_data = '0;
    exp_t        sb[$];

    pullup (DTH);
    assign DTH = sens_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dth_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk           (clk),
        .rst_n         (rst),
        .start         (start),
        .DTH           (DTH),
        .error         (error),
        .DTH_data      (DTH_data),
        .DHT_data_ready(rdy)
    );

    function automatic logic [39:0] mk_frame(input logic [31:0] d);
        logic [7:0] s;
        s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
        return {d, s};
    endfunction

    // One full host/sensor exchange. abort_bit >= 0 asserts reset in that bit's high phase.
    task automatic do_measure(input logic [39:0] frame, input int nbits, input bit respond,
                              input bit end_pulse, input bit poke, input int abort_bit,
                              output int lat);
        int low;
        lat = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (rdy !== 1'b0 || error !== 1'b0)
            $display("FAIL start_clear: rdy=%b error=%b want 0 0", rdy, error);
        low = 0;
        while (DTH === 1'b0 && low < 2 * START_LOW) begin
            start = (poke && low == 100);
            @(negedge clk);
            low++;
        end
        start = 1'b0;
        total++;
        if (low != START_LOW) begin
            bad++;
            $display("FAIL start_low_len: got %0d cycles want %0d", low, START_LOW);
        end
        if (!respond) begin
            while (error !== 1'b1 && lat < 4 * TO + START_HIGH) begin
                @(negedge clk);
                lat++;
            end
            return;
        end
        repeat (START_HIGH + 3) @(negedge clk);
        sens_low = 1'b1;
        #1;
        total++;
        if (DTH !== 1'b0) begin
            bad++;
            $display("FAIL released: line=%b want 0 from sensor pull-down", DTH);
        end
        repeat (RESP) @(negedge clk);
        sens_low = 1'b0;
        repeat (RESP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sens_low = 1'b1;
            start = (poke && i == 5);
            @(negedge clk);
            start = 1'b0;
            repeat (BLOW - 1) @(negedge clk);
            sens_low = 1'b0;
            if (i == abort_bit) begin
                repeat (4) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                total++;
                if (DTH_data !== 40'h0 || rdy !== 1'b0 || error !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid_bit: data=%h rdy=%b err=%b want 0 0 0", DTH_data, rdy, error);
                end
                total++;
                if (DTH !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_mid_bit_line: line=%b want 1 (released)", DTH);
                end
                return;
            end
            repeat (frame[39-i] ? H1 : H0) @(negedge clk);
        end
        if (end_pulse) begin
            sens_low = 1'b1;
            repeat (BLOW) @(negedge clk);
            sens_low = 1'b0;
        end
        while (!(rdy === 1'b1 || error === 1'b1) && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat >= 300) begin
            bad++;
            $display("FAIL done_timeout: no completion after %0d cycles", lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (DTH_data !== 40'h0) begin bad++; $display("FAIL reset_data: got %h want 0", DTH_data); end
        total++;
        if (rdy !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", rdy); end
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        total++;
        if (DTH !== 1'b1) begin bad++; $display("FAIL reset_line: got %b want 1 (released)", DTH); end
        @(negedge clk); rst = 1'b0;
        last_data = '0;
    endtask

    task automatic test_good_frame();
        logic [39:0] f;
        exp_t e;
        int lat;
        f = 40'h35_00_18_00_4D;
        sb.push_back('{data: f, rdy: 1'b1, err: 1'b0});
        last_data = f;
        do_measure(f, 40, 1'b1, 1'b1, 1'b1, -1, lat);
        e = sb.pop_front();
        total++;
        if (DTH_data !== e.data) begin bad++; $display("FAIL good_data: got %h want %h", DTH_data, e.data); end
        total++;
        if (rdy !== e.rdy) begin bad++; $display("FAIL good_ready: got %b want %b", rdy, e.rdy); end
        total++;
        if (error !== e.err) begin bad++; $display("FAIL good_error: got %b want %b", error, e.err); end
        repeat (10) @(negedge clk);
        total++;
        if (rdy !== 1'b1 || DTH_data !== f || DTH !== 1'b1) begin
            bad++;
            $display("FAIL good_hold: rdy=%b data=%h line=%b want 1 %h 1", rdy, DTH_data, DTH, f);
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] f;
        exp_t e;
        int lat;
        for (int n = 0; n < 2; n++) begin
            f = (n == 0) ? mk_frame(32'hFFFF_FFFF) : mk_frame($urandom);
            sb.push_back('{data: f, rdy: 1'b1, err: 1'b0});
            last_data = f;
            do_measure(f, 40, 1'b1, 1'b1, 1'b0, -1, lat);
            e = sb.pop_front();
            total++;
            if (DTH_data !== e.data || rdy !== e.rdy || error !== e.err)
                begin bad++; $display("FAIL b2b_%0d: data=%h rdy=%b err=%b want %h %b %b",
                                      n, DTH_data, rdy, error, e.data, e.rdy, e.err); end
        end
    endtask

    task automatic test_bad_checksum();
        exp_t e;
        int lat;
        sb.push_back('{data: last_data, rdy: 1'b0, err: 1'b1});
        do_measure(40'h35_00_18_00_4E, 40, 1'b1, 1'b1, 1'b0, -1, lat);
        e = sb.pop_front();
        total++;
        if (DTH_data !== e.data) begin bad++; $display("FAIL badcs_data: got %h want %h", DTH_data, e.data); end
        total++;
        if (rdy !== e.rdy || error !== e.err)
            begin bad++; $display("FAIL badcs_flags: rdy=%b err=%b want %b %b", rdy, error, e.rdy, e.err); end
    endtask

    task automatic test_no_response();
        exp_t e;
        int lat;
        sb.push_back('{data: last_data, rdy: 1'b0, err: 1'b1});
        do_measure(40'h0, 0, 1'b0, 1'b0, 1'b0, -1, lat);
        e = sb.pop_front();
        total++;
        if (lat < TO || lat > TO + START_HIGH + 6)
            begin bad++; $display("FAIL noresp_latency: got %0d cycles want %0d..%0d", lat, TO, TO + START_HIGH + 6); end
        total++;
        if (DTH_data !== e.data || rdy !== e.rdy || error !== e.err)
            begin bad++; $display("FAIL noresp_out: data=%h rdy=%b err=%b want %h %b %b",
                                  DTH_data, rdy, error, e.data, e.rdy, e.err); end
        repeat (3) @(negedge clk);
        total++;
        if (DTH !== 1'b1) begin bad++; $display("FAIL noresp_line: got %b want 1 (released)", DTH); end
    endtask

    task automatic test_stuck_mid();
        exp_t e;
        int lat;
        sb.push_back('{data: last_data, rdy: 1'b0, err: 1'b1});
        do_measure(mk_frame(32'h0A5C_3E71), 12, 1'b1, 1'b0, 1'b0, -1, lat);
        e = sb.pop_front();
        total++;
        if (DTH_data !== e.data || rdy !== e.rdy || error !== e.err)
            begin bad++; $display("FAIL stuck_out: data=%h rdy=%b err=%b want %h %b %b",
                                  DTH_data, rdy, error, e.data, e.rdy, e.err); end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_measure(mk_frame(32'h1234_5678), 40, 1'b1, 1'b1, 1'b0, 20, lat);
        last_data = '0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        total++;
        if (DTH !== 1'b0) begin bad++; $display("FAIL restart_drive: line=%b want 0", DTH); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (DTH !== 1'b1) begin bad++; $display("FAIL reset_mid_start_line: line=%b want 1 (released)", DTH); end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_bad_checksum();
        test_no_response();
        test_stuck_mid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
